// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between the in-order WB stage and a long-latency unit.
// Buffers LLU results in a small FIFO and stalls ID on hazards against pending LLU writes.
module regfile_wb_arbiter #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWrite_wb,
   input  logic [4:0]  rdAddr_wb,
   input  logic [31:0] RegWriteData_wb,
   input  logic        llu_issue_valid,
   input  logic [4:0]  llu_issue_rd,
   input  logic        llu_done_valid,
   input  logic [4:0]  llu_done_rd,
   input  logic [31:0] llu_done_data,
   output logic        llu_done_ready,
   input  logic [4:0]  rs1Addr_id,
   input  logic [4:0]  rs2Addr_id,
   input  logic [4:0]  rdAddr_id,
   input  logic        RegWrite_id,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        stall_id,
   output logic        sb_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);

   // FIFO storage and control
   logic [4:0]    fifo_rd   [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic [4:0]    head_rd;
   logic [31:0]   head_data;

   logic          wb_act;
   logic          grant;
   logic          issue_act;

   logic [31:0]   pending;
   logic [31:0]   pending_nxt;
   logic          sb_evt;

   logic [SW-1:0] starve_cnt;
   logic          force_bubble;

   logic          haz_rs1;
   logic          haz_rs2;
   logic          haz_rd;

   assign fifo_full  = (count == CW'(DEPTH));
   assign fifo_empty = (count == '0);
   assign head_rd    = fifo_rd[rd_ptr];
   assign head_data  = fifo_data[rd_ptr];

   // Ready comes from the registered count only: a pop this cycle does not free a slot yet.
   assign llu_done_ready = !fifo_full;
   assign push           = llu_done_valid && llu_done_ready && (llu_done_rd != 5'd0);

   assign wb_act    = RegWrite_wb && (rdAddr_wb != 5'd0);
   assign grant     = !wb_act && !fifo_empty;
   assign pop       = grant;
   assign issue_act = llu_issue_valid && (llu_issue_rd != 5'd0);

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = 5'd0;
      rf_wdata = 32'd0;
      if (wb_act) begin
         rf_we    = 1'b1;
         rf_waddr = rdAddr_wb;
         rf_wdata = RegWriteData_wb;
      end else if (grant) begin
         rf_we    = 1'b1;
         rf_waddr = head_rd;
         rf_wdata = head_data;
      end
   end

   // NOTE: every output of a combinational block gets a default before any branch;
   // a path that leaves one unassigned infers a latch.
   always_comb begin
      pending_nxt = pending;
      sb_evt      = 1'b0;
      if (pop) begin
         if (!pending[head_rd]) sb_evt = 1'b1;
         pending_nxt[head_rd] = 1'b0;
      end
      // Applied after the clear so that a same-rd set and clear resolves to set.
      if (issue_act) begin
         if (pending[llu_issue_rd]) sb_evt = 1'b1;
         pending_nxt[llu_issue_rd] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         pending    <= '0;
         sb_err     <= 1'b0;
         starve_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count   <= count + CW'(push) - CW'(pop);
         pending <= pending_nxt;
         if (sb_evt) sb_err <= 1'b1;

         if (fifo_empty || grant) begin
            starve_cnt <= '0;
         end else if (starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
         end
      end
   end

   // NOTE: the FIFO payload is not reset; entries are only read when count says
   // they are valid, so clearing them would just add reset fan-out.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wr_ptr]   <= llu_done_rd;
         fifo_data[wr_ptr] <= llu_done_data;
      end
   end

   assign force_bubble = (starve_cnt == SW'(STARVE_MAX));

   assign haz_rs1  = (rs1Addr_id != 5'd0) && pending[rs1Addr_id];
   assign haz_rs2  = (rs2Addr_id != 5'd0) && pending[rs2Addr_id];
   assign haz_rd   = RegWrite_id && (rdAddr_id != 5'd0) && pending[rdAddr_id];
   assign stall_id = haz_rs1 || haz_rs2 || haz_rd || force_bubble;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: scoreboard of expected register-file
// writes, a table of ID hazard vectors and directed multi-cycle sequences.
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        RegWrite_wb;
   logic [4:0]  rdAddr_wb;
   logic [31:0] RegWriteData_wb;
   logic        llu_issue_valid;
   logic [4:0]  llu_issue_rd;
   logic        llu_done_valid;
   logic [4:0]  llu_done_rd;
   logic [31:0] llu_done_data;
   logic        llu_done_ready;
   logic [4:0]  rs1Addr_id;
   logic [4:0]  rs2Addr_id;
   logic [4:0]  rdAddr_id;
   logic        RegWrite_id;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        stall_id;
   logic        sb_err;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       rw;
      logic       exp_stall;
   } stall_vec_t;

   wr_t        exp_q[$];
   wr_t        m_e;
   stall_vec_t vecs[10];

   regfile_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .RegWrite_wb     (RegWrite_wb),
      .rdAddr_wb       (rdAddr_wb),
      .RegWriteData_wb (RegWriteData_wb),
      .llu_issue_valid (llu_issue_valid),
      .llu_issue_rd    (llu_issue_rd),
      .llu_done_valid  (llu_done_valid),
      .llu_done_rd     (llu_done_rd),
      .llu_done_data   (llu_done_data),
      .llu_done_ready  (llu_done_ready),
      .rs1Addr_id      (rs1Addr_id),
      .rs2Addr_id      (rs2Addr_id),
      .rdAddr_id       (rdAddr_id),
      .RegWrite_id     (RegWrite_id),
      .rf_we           (rf_we),
      .rf_waddr        (rf_waddr),
      .rf_wdata        (rf_wdata),
      .stall_id        (stall_id),
      .sb_err          (sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic idle();
      RegWrite_wb     = 1'b0;
      rdAddr_wb       = 5'd0;
      RegWriteData_wb = 32'd0;
      llu_issue_valid = 1'b0;
      llu_issue_rd    = 5'd0;
      llu_done_valid  = 1'b0;
      llu_done_rd     = 5'd0;
      llu_done_data   = 32'd0;
      rs1Addr_id      = 5'd0;
      rs2Addr_id      = 5'd0;
      rdAddr_id       = 5'd0;
      RegWrite_id     = 1'b0;
   endtask

   task automatic issue_step(input logic [4:0] rd);
      cyc(); idle();
      llu_issue_valid = 1'b1;
      llu_issue_rd    = rd;
      at_neg();
   endtask

   task automatic done_step(input logic [4:0] rd, input logic [31:0] data);
      cyc(); idle();
      llu_done_valid = 1'b1;
      llu_done_rd    = rd;
      llu_done_data  = data;
      at_neg();
   endtask

   // Scoreboard: WB always wins the port; otherwise the oldest accepted LLU result is due.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (RegWrite_wb && rdAddr_wb != 5'd0) begin
            check("wb_we", rf_we, 1'b1);
            check("wb_waddr", rf_waddr, rdAddr_wb);
            check("wb_wdata", rf_wdata, RegWriteData_wb);
         end else if (exp_q.size() != 0) begin
            m_e = exp_q.pop_front();
            check("llu_we", rf_we, 1'b1);
            check("llu_waddr", rf_waddr, m_e.rd);
            check("llu_wdata", rf_wdata, m_e.data);
         end else begin
            check("idle_we", rf_we, 1'b0);
         end
         check("x0_write", rf_we && rf_waddr == 5'd0, 1'b0);
         if (llu_done_valid && llu_done_ready && llu_done_rd != 5'd0)
            exp_q.push_back('{rd: llu_done_rd, data: llu_done_data});
      end
   end

   initial begin
      vecs[0] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0};
      vecs[1] = '{5'd20, 5'd0,  5'd0,  1'b0, 1'b1};
      vecs[2] = '{5'd0,  5'd21, 5'd0,  1'b0, 1'b1};
      vecs[3] = '{5'd0,  5'd0,  5'd20, 1'b1, 1'b1};
      vecs[4] = '{5'd0,  5'd0,  5'd20, 1'b0, 1'b0};
      vecs[5] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0};
      vecs[6] = '{5'd19, 5'd22, 5'd19, 1'b1, 1'b0};
      vecs[7] = '{5'd21, 5'd20, 5'd0,  1'b0, 1'b1};
      vecs[8] = '{5'd0,  5'd0,  5'd21, 1'b1, 1'b1};
      vecs[9] = '{5'd1,  5'd2,  5'd3,  1'b1, 1'b0};

      idle();
      rst = 1'b1;
      repeat (2) cyc();
      rst = 1'b0;
      at_neg();
      check("rst_ready", llu_done_ready, 1'b1);
      check("rst_we", rf_we, 1'b0);
      check("rst_stall", stall_id, 1'b0);
      check("rst_sb_err", sb_err, 1'b0);

      // Issue is visible to ID only from the next cycle.
      cyc(); idle();
      llu_issue_valid = 1'b1; llu_issue_rd = 5'd5; rs1Addr_id = 5'd5;
      at_neg();
      check("issue_same_cycle_stall", stall_id, 1'b0);
      cyc(); idle(); rs1Addr_id = 5'd5;
      at_neg();
      check("raw_rs1_stall", stall_id, 1'b1);
      cyc(); idle();
      at_neg();
      check("rs1_zero_stall", stall_id, 1'b0);

      // Completion: grant one cycle after acceptance, pending clears the cycle after.
      done_step(5'd5, 32'hDEADBEEF);
      check("done_ready", llu_done_ready, 1'b1);
      cyc(); idle(); rs1Addr_id = 5'd5;
      at_neg();
      check("grant_waddr", rf_waddr, 5'd5);
      check("grant_cycle_stall", stall_id, 1'b1);
      cyc(); idle(); rs1Addr_id = 5'd5;
      at_neg();
      check("after_grant_stall", stall_id, 1'b0);

      // Starvation: WB holds the port while rd=7 waits.
      issue_step(5'd7);
      done_step(5'd7, 32'h0000_0077);
      for (int i = 0; i < 6; i++) begin
         cyc(); idle();
         RegWrite_wb = 1'b1; rdAddr_wb = 5'd3; RegWriteData_wb = 32'h3000_0000 + i;
         at_neg();
         check($sformatf("starve_stall_%0d", i), stall_id, (i >= 4) ? 1'b1 : 1'b0);
      end
      cyc(); idle();
      at_neg();
      check("starve_grant_waddr", rf_waddr, 5'd7);
      check("starve_grant_stall", stall_id, 1'b1);
      cyc(); idle();
      at_neg();
      check("starve_clear_stall", stall_id, 1'b0);

      // Fill the FIFO, hold a third result, drain across the pointer wrap.
      issue_step(5'd1);
      issue_step(5'd2);
      issue_step(5'd3);
      for (int i = 0; i < 4; i++) begin
         cyc(); idle();
         RegWrite_wb = 1'b1; rdAddr_wb = 5'd4; RegWriteData_wb = 32'h4444_0000 + i;
         llu_done_valid = 1'b1;
         llu_done_rd    = (i == 0) ? 5'd1 : (i == 1) ? 5'd2 : 5'd3;
         llu_done_data  = (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : 32'h33;
         at_neg();
         check($sformatf("fill_ready_%0d", i), llu_done_ready, (i < 2) ? 1'b1 : 1'b0);
      end
      cyc(); idle();
      llu_done_valid = 1'b1; llu_done_rd = 5'd3; llu_done_data = 32'h33;
      at_neg();
      check("no_pop_credit_ready", llu_done_ready, 1'b0);
      cyc(); idle();
      llu_done_valid = 1'b1; llu_done_rd = 5'd3; llu_done_data = 32'h33;
      at_neg();
      check("reopen_ready", llu_done_ready, 1'b1);
      repeat (2) begin cyc(); idle(); at_neg(); end

      // x0 WB write leaves the port free for the FIFO head.
      issue_step(5'd11);
      done_step(5'd11, 32'hB0B0_1111);
      cyc(); idle();
      RegWrite_wb = 1'b1; rdAddr_wb = 5'd0; RegWriteData_wb = 32'hBAD0_0000;
      at_neg();
      check("x0_wb_grant_waddr", rf_waddr, 5'd11);
      check("x0_wb_grant_wdata", rf_wdata, 32'hB0B0_1111);

      // Results to x0 are dropped at push.
      done_step(5'd0, 32'hFFFF_FFFF);
      check("x0_done_ready", llu_done_ready, 1'b1);
      cyc(); idle(); at_neg();
      check("x0_drop_sb_err", sb_err, 1'b0);

      // Hazard table with rd 20 and 21 pending.
      issue_step(5'd20);
      issue_step(5'd21);
      foreach (vecs[i]) begin
         cyc(); idle();
         rs1Addr_id = vecs[i].rs1; rs2Addr_id = vecs[i].rs2;
         rdAddr_id = vecs[i].rd; RegWrite_id = vecs[i].rw;
         at_neg();
         check($sformatf("vec_stall_%0d", i), stall_id, vecs[i].exp_stall);
      end
      done_step(5'd20, 32'h2020_2020);
      done_step(5'd21, 32'h2121_2121);
      repeat (2) begin cyc(); idle(); at_neg(); end
      check("clean_sb_err", sb_err, 1'b0);

      // Double issue raises sticky sb_err; reset mid-FIFO discards everything.
      issue_step(5'd9);
      issue_step(5'd9);
      check("double_issue_pre", sb_err, 1'b0);
      cyc(); idle(); at_neg();
      check("double_issue_err", sb_err, 1'b1);
      issue_step(5'd12);
      cyc(); idle();
      RegWrite_wb = 1'b1; rdAddr_wb = 5'd4; RegWriteData_wb = 32'h4;
      llu_done_valid = 1'b1; llu_done_rd = 5'd12; llu_done_data = 32'h1212;
      at_neg();
      cyc(); idle();
      RegWrite_wb = 1'b1; rdAddr_wb = 5'd4; RegWriteData_wb = 32'h5;
      at_neg();
      check("sticky_err", sb_err, 1'b1);
      cyc(); idle(); rst = 1'b1; at_neg();
      cyc(); idle(); rst = 1'b0;
      rs1Addr_id = 5'd12; rs2Addr_id = 5'd9;
      at_neg();
      check("rst2_ready", llu_done_ready, 1'b1);
      check("rst2_we", rf_we, 1'b0);
      check("rst2_sb_err", sb_err, 1'b0);
      check("rst2_stall", stall_id, 1'b0);

      // Pop of a result that was never issued.
      done_step(5'd13, 32'h1313_1313);
      cyc(); idle(); at_neg();
      check("unissued_pop_pre", sb_err, 1'b0);
      cyc(); idle(); at_neg();
      check("unissued_pop_err", sb_err, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
